dshot_frame_rx: RTL



---
 rtl/dshot_frame_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dshot_frame_rx.sv
// DShot single-channel frame receiver: pulse-width bit decode, 16-bit frame assembly, CRC check.
// Optional watchdog failsafe is enabled by defining DSHOT_FAILSAFE_EN.
module dshot_frame_rx #(
    parameter int BIT_THRESH = 60,
    parameter int MIN_HIGH   = 8,
    parameter int MAX_HIGH   = 100,
    parameter int GAP_CYCLES = 200
`ifdef DSHOT_FAILSAFE_EN
    ,
    parameter int FAILSAFE_CYCLES = 1600000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dshot_in,
    output logic [10:0] throttle,
    output logic        telemetry,
    output logic [7:0]  speed,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        failsafe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [6:0] THRESH_C = 7'(BIT_THRESH);
    localparam logic [6:0] MIN_C    = 7'(MIN_HIGH);
    localparam logic [6:0] MAX_C    = 7'(MAX_HIGH);
    localparam logic [7:0] GAP_C    = 8'(GAP_CYCLES);

    function automatic logic [3:0] crc4(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    function automatic logic [7:0] speed_of(input logic [10:0] thr);
        logic [10:0] diff;
        diff = thr - 11'd48;
        if (thr < 11'd48) begin
            return 8'd0;
        end else begin
            return diff[10:3];
        end
    endfunction

    logic        sync1_r, s_r, s_prev_r;
    logic        rise_s, fall_s;
    state_t      state_r, state_s;
    logic [6:0]  hi_cnt_r, hi_cnt_s;
    logic [7:0]  lo_cnt_r, lo_cnt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic [14:0] shift_r, shift_s;
    logic        bit_s;
    logic [15:0] frame_s;
    logic [10:0] throttle_s;
    logic        telemetry_s;
    logic [7:0]  speed_s;
    logic        frame_valid_s, crc_err_s;
`ifdef DSHOT_FAILSAFE_EN
    localparam logic [20:0] FS_C = 21'(FAILSAFE_CYCLES);
    logic [20:0] wd_r, wd_s;
    logic        failsafe_s;
`else
    assign failsafe = 1'b0;
`endif

    assign rise_s = s_r & ~s_prev_r;
    assign fall_s = ~s_r & s_prev_r;

    // Next-state, bit decode and frame evaluation.
    always_comb begin
        state_s       = state_r;
        hi_cnt_s      = hi_cnt_r;
        lo_cnt_s      = lo_cnt_r;
        bit_cnt_s     = bit_cnt_r;
        shift_s       = shift_r;
        bit_s         = 1'b0;
        frame_s       = 16'd0;
        throttle_s    = throttle;
        telemetry_s   = telemetry;
        speed_s       = speed;
        frame_valid_s = 1'b0;
        crc_err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    hi_cnt_s = 7'd0;
                    state_s  = HIGH;
                end else begin
                    state_s = IDLE;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    state_s = LOW;
                    if (hi_cnt_r >= MIN_C) begin
                        bit_s    = (hi_cnt_r >= THRESH_C);
                        lo_cnt_s = 8'd0;
                        if (bit_cnt_r == 4'd15) begin
                            // Frame boundary is by count, so the next rise may start a new frame at once.
                            frame_s   = {shift_r, bit_s};
                            bit_cnt_s = 4'd0;
                            shift_s   = 15'd0;
                            if (crc4(frame_s[15:4]) == frame_s[3:0]) begin
                                throttle_s    = frame_s[15:5];
                                telemetry_s   = frame_s[4];
                                speed_s       = speed_of(frame_s[15:5]);
                                frame_valid_s = 1'b1;
                            end else begin
                                crc_err_s = 1'b1;
                            end
                        end else begin
                            shift_s   = {shift_r[13:0], bit_s};
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end else if (hi_cnt_r >= MAX_C - 7'd1) begin
                    hi_cnt_s  = MAX_C;
                    bit_cnt_s = 4'd0;
                    shift_s   = 15'd0;
                    state_s   = IDLE;
                end else begin
                    hi_cnt_s = hi_cnt_r + 7'd1;
                end
            end
            LOW: begin
                if (rise_s) begin
                    hi_cnt_s = 7'd0;
                    state_s  = HIGH;
                end else if (lo_cnt_r >= GAP_C - 8'd1) begin
                    lo_cnt_s  = GAP_C;
                    bit_cnt_s = 4'd0;
                    shift_s   = 15'd0;
                    state_s   = IDLE;
                end else begin
                    lo_cnt_s = lo_cnt_r + 8'd1;
                end
            end
            default: begin
                bit_cnt_s = 4'd0;
                shift_s   = 15'd0;
                state_s   = IDLE;
            end
        endcase
`ifdef DSHOT_FAILSAFE_EN
        // A valid frame both feeds the watchdog and clears the failsafe in the same cycle.
        if (frame_valid_s) begin
            wd_s       = 21'd0;
            failsafe_s = 1'b0;
        end else if (wd_r >= FS_C - 21'd1) begin
            wd_s       = FS_C;
            failsafe_s = 1'b1;
            throttle_s = 11'd0;
            speed_s    = 8'd0;
        end else begin
            wd_s       = wd_r + 21'd1;
            failsafe_s = failsafe;
        end
`endif
    end

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b0;
            s_r         <= 1'b0;
            s_prev_r    <= 1'b0;
            state_r     <= IDLE;
            hi_cnt_r    <= 7'd0;
            lo_cnt_r    <= 8'd0;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 15'd0;
            throttle    <= 11'd0;
            telemetry   <= 1'b0;
            speed       <= 8'd0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
`ifdef DSHOT_FAILSAFE_EN
            wd_r        <= 21'd0;
            failsafe    <= 1'b1;
`endif
        end else begin
            sync1_r     <= dshot_in;
            s_r         <= sync1_r;
            s_prev_r    <= s_r;
            state_r     <= state_s;
            hi_cnt_r    <= hi_cnt_s;
            lo_cnt_r    <= lo_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            throttle    <= throttle_s;
            telemetry   <= telemetry_s;
            speed       <= speed_s;
            frame_valid <= frame_valid_s;
            crc_err     <= crc_err_s;
`ifdef DSHOT_FAILSAFE_EN
            wd_r        <= wd_s;
            failsafe    <= failsafe_s;
`endif
        end
    end

endmodule
